// File: rtl/imm_encode_packer_if.sv
// Request/response bundle for the immediate encoder-packer.
// The master drives requests and takes packed words; the slave is the packer.
interface imm_encode_packer_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        imm_src;
    logic [31:0]       base_instr;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, imm_src, base_instr, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, imm_src, base_instr, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/imm_encode_packer.sv
// Packs a signed immediate into RISC-V I/S/B/J fields of a base instruction,
// range/alignment-checks it and emits the word with a sequential imem address.
module imm_encode_packer #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    imm_encode_packer_if.slave   bus,
    output logic                 err_range,
    output logic                 err_align,
    output logic [15:0]          err_count
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] wr_ptr;

    logic [31:0] packed_instr;
    logic        range_bad;
    logic        align_bad;
    logic        accept;
    logic        good;
    logic        bad;

    assign bus.in_ready  = !clear && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign bad    = range_bad || align_bad;
    assign good   = accept && !bad;

    // A value fits a signed field when every bit above the field's top bit
    // matches that top bit, i.e. the checked slice is all ones or all zeros.
    always_comb begin
        packed_instr = bus.base_instr;
        range_bad    = 1'b0;
        align_bad    = 1'b0;
        case (bus.imm_src)
            2'b00: begin
                packed_instr[31:20] = bus.imm[11:0];
                range_bad = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            2'b01: begin
                packed_instr[31:25] = bus.imm[11:5];
                packed_instr[11:7]  = bus.imm[4:0];
                range_bad = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
            end
            2'b10: begin
                packed_instr[31]    = bus.imm[12];
                packed_instr[30:25] = bus.imm[10:5];
                packed_instr[11:8]  = bus.imm[4:1];
                packed_instr[7]     = bus.imm[11];
                range_bad = !((&bus.imm[31:12]) || !(|bus.imm[31:12]));
                align_bad = bus.imm[0];
            end
            default: begin
                packed_instr[31]    = bus.imm[20];
                packed_instr[30:21] = bus.imm[10:1];
                packed_instr[20]    = bus.imm[11];
                packed_instr[19:12] = bus.imm[19:12];
                range_bad = !((&bus.imm[31:20]) || !(|bus.imm[31:20]));
                align_bad = bus.imm[0];
            end
        endcase
    end

    // A new good word overwrites the held one in the same cycle it drains,
    // so back-to-back traffic flows without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_addr_q  <= BASE;
            wr_ptr      <= BASE;
            err_range   <= 1'b0;
            err_align   <= 1'b0;
            err_count   <= 16'h0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
            wr_ptr      <= BASE;
            err_range   <= 1'b0;
            err_align   <= 1'b0;
            err_count   <= 16'h0;
        end else begin
            err_range <= accept && range_bad;
            err_align <= accept && align_bad;
            if (good) begin
                out_valid_q <= 1'b1;
                out_instr_q <= packed_instr;
                out_addr_q  <= wr_ptr;
                wr_ptr      <= wr_ptr + ADDR_W'(4);
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && bad && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
endmodule
